pitch_tracker: RTL

- Downstream of the FFT peak finder in the microphone pitch-detect chain.
- Consumes one (peak, peak_k) result per FFT frame, rejects weak, DC and out-of-band frames, and declares a pitch only after several consecutive frames agree.
- Converts the tracked bin index to an integer frequency in Hz.
- Feeds note-matching / game logic with a stable pitch_k / pitch_hz pair plus update and lost events.

---
 rtl/pitch_tracker_pkg.sv | 18 +
 rtl/pitch_tracker_bin_to_hz.sv | 49 ++++
 rtl/pitch_tracker.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pitch_tracker_pkg.sv
// Shared types and constants for the microphone pitch-detect chain.
package pitch_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CANDIDATE = 2'd1,
      LOCKED    = 2'd2
   } tracker_state_t;

   localparam int DEF_NSAMPLES = 256;
   localparam int DEF_FS_HZ    = 48000;

   // Width of k*FS_HZ, so the bin-to-Hz product never loses high bits before the shift.
   function automatic int hz_prod_width(input int nbits, input int fs_hz);
      return nbits + $clog2(fs_hz + 1);
   endfunction

endpackage

// File: rtl/pitch_tracker_bin_to_hz.sv
// Registered bin-index to Hz conversion: hz = (k*FS_HZ) >> NBits.
module bin_to_hz
   import pitch_pkg::*;
#(
   parameter int NBits = 8,
   parameter int FS_HZ = DEF_FS_HZ,
   parameter int FW    = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic [NBits-1:0] k,
   output logic [FW-1:0]    hz
);

   localparam int PW = hz_prod_width(NBits, FS_HZ);

   logic [PW-1:0] prod_s;
   logic [PW-1:0] shifted_s;
   logic [FW-1:0] hz_d;
   logic [FW-1:0] hz_q;

   // Multiply, scale down by the FFT length, and pick load/clear/hold.
   always_comb begin
      prod_s    = PW'(k) * PW'(FS_HZ);
      shifted_s = prod_s >> NBits;
      hz_d      = hz_q;
      if (load) begin
         hz_d = FW'(shifted_s);
      end else if (clear) begin
         hz_d = {FW{1'b0}};
      end else begin
         hz_d = hz_q;
      end
   end

   // Output frequency register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hz_q <= {FW{1'b0}};
      end else begin
         hz_q <= hz_d;
      end
   end

   assign hz = hz_q;

endmodule

// File: rtl/pitch_tracker.sv
// Frame-by-frame pitch tracker: voicing gate, lock/track/release FSM, and
// a registered output stage that publishes pitch_k/pitch_hz two cycles after a frame.
module pitch_tracker
   import pitch_pkg::*;
#(
   parameter int NSamples       = DEF_NSAMPLES,
   parameter int W              = 33,
   parameter int NBits          = $clog2(NSamples),
   parameter int FS_HZ          = DEF_FS_HZ,
   parameter int FW             = $clog2(FS_HZ / 2 + 1),
   parameter int MAG_THRESH     = 1000,
   parameter int MIN_K          = 1,
   parameter int LOCK_FRAMES    = 3,
   parameter int TOL_BINS       = 1,
   parameter int RELEASE_FRAMES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [W-1:0]     peak,
   input  logic [NBits-1:0] peak_k,
   input  logic             peak_valid,
   output logic [NBits-1:0] pitch_k,
   output logic [FW-1:0]    pitch_hz,
   output logic             pitch_valid,
   output logic             pitch_update,
   output logic             pitch_lost
);

   tracker_state_t   state_q, state_d;
   logic [NBits-1:0] cand_k_q, cand_k_d;
   logic [NBits-1:0] track_k_q, track_k_d;
   logic [3:0]       match_cnt_q, match_cnt_d;
   logic [3:0]       miss_cnt_q, miss_cnt_d;
   logic             upd_req_q, upd_req_d;
   logic             lost_req_q, lost_req_d;

   logic [NBits-1:0] pitch_k_q, pitch_k_d;
   logic             pitch_valid_q, pitch_valid_d;
   logic             pitch_update_q, pitch_update_d;
   logic             pitch_lost_q, pitch_lost_d;

   logic             voiced_s;
   logic             match_s;
   logic [NBits-1:0] ref_k_s;
   logic [NBits-1:0] diff_s;
   logic [3:0]       match_inc_s;
   logic [3:0]       miss_inc_s;

   // Voicing gate and wrap-free distance to the current reference bin.
   always_comb begin
      voiced_s    = (peak >= W'(MAG_THRESH)) && (peak_k >= NBits'(MIN_K)) && (peak_k != {NBits{1'b0}});
      ref_k_s     = (state_q == LOCKED) ? track_k_q : cand_k_q;
      diff_s      = (peak_k >= ref_k_s) ? (peak_k - ref_k_s) : (ref_k_s - peak_k);
      match_s     = voiced_s && (diff_s <= NBits'(TOL_BINS));
      match_inc_s = match_cnt_q + 4'd1;
      miss_inc_s  = miss_cnt_q + 4'd1;
   end

   // Stage 1 next-state: only a peak_valid cycle may move the tracker.
   always_comb begin
      state_d     = state_q;
      cand_k_d    = cand_k_q;
      track_k_d   = track_k_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      upd_req_d   = 1'b0;
      lost_req_d  = 1'b0;
      if (peak_valid) begin
         case (state_q)
            IDLE: begin
               if (voiced_s) begin
                  cand_k_d    = peak_k;
                  match_cnt_d = 4'd1;
                  if (LOCK_FRAMES == 1) begin
                     state_d    = LOCKED;
                     track_k_d  = peak_k;
                     miss_cnt_d = 4'd0;
                     upd_req_d  = 1'b1;
                  end else begin
                     state_d = CANDIDATE;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            CANDIDATE: begin
               if (match_s) begin
                  cand_k_d    = peak_k;
                  match_cnt_d = match_inc_s;
                  if (match_inc_s == 4'(LOCK_FRAMES)) begin
                     state_d    = LOCKED;
                     track_k_d  = peak_k;
                     miss_cnt_d = 4'd0;
                     upd_req_d  = 1'b1;
                  end else begin
                     state_d = CANDIDATE;
                  end
               end else if (voiced_s) begin
                  cand_k_d    = peak_k;
                  match_cnt_d = 4'd1;
               end else begin
                  state_d     = IDLE;
                  match_cnt_d = 4'd0;
               end
            end
            LOCKED: begin
               if (match_s) begin
                  track_k_d  = peak_k;
                  miss_cnt_d = 4'd0;
                  upd_req_d  = 1'b1;
               end else if (miss_inc_s == 4'(RELEASE_FRAMES)) begin
                  state_d     = IDLE;
                  match_cnt_d = 4'd0;
                  miss_cnt_d  = 4'd0;
                  lost_req_d  = 1'b1;
               end else begin
                  miss_cnt_d = miss_inc_s;
               end
            end
            default: begin
               state_d     = IDLE;
               match_cnt_d = 4'd0;
               miss_cnt_d  = 4'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Stage 2 next-state: publish or clear the pitch one cycle after the request.
   always_comb begin
      pitch_k_d      = pitch_k_q;
      pitch_valid_d  = pitch_valid_q;
      pitch_update_d = 1'b0;
      pitch_lost_d   = 1'b0;
      if (upd_req_q) begin
         pitch_k_d      = track_k_q;
         pitch_valid_d  = 1'b1;
         pitch_update_d = 1'b1;
      end else if (lost_req_q) begin
         pitch_k_d     = {NBits{1'b0}};
         pitch_valid_d = 1'b0;
         pitch_lost_d  = 1'b1;
      end else begin
         pitch_k_d = pitch_k_q;
      end
   end

   // Tracker and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         cand_k_q       <= {NBits{1'b0}};
         track_k_q      <= {NBits{1'b0}};
         match_cnt_q    <= 4'd0;
         miss_cnt_q     <= 4'd0;
         upd_req_q      <= 1'b0;
         lost_req_q     <= 1'b0;
         pitch_k_q      <= {NBits{1'b0}};
         pitch_valid_q  <= 1'b0;
         pitch_update_q <= 1'b0;
         pitch_lost_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         cand_k_q       <= cand_k_d;
         track_k_q      <= track_k_d;
         match_cnt_q    <= match_cnt_d;
         miss_cnt_q     <= miss_cnt_d;
         upd_req_q      <= upd_req_d;
         lost_req_q     <= lost_req_d;
         pitch_k_q      <= pitch_k_d;
         pitch_valid_q  <= pitch_valid_d;
         pitch_update_q <= pitch_update_d;
         pitch_lost_q   <= pitch_lost_d;
      end
   end

   bin_to_hz #(
      .NBits (NBits),
      .FS_HZ (FS_HZ),
      .FW    (FW)
   ) u_bin_to_hz (
      .clk   (clk),
      .reset (reset),
      .load  (upd_req_q),
      .clear (lost_req_q),
      .k     (track_k_q),
      .hz    (pitch_hz)
   );

   assign pitch_k      = pitch_k_q;
   assign pitch_valid  = pitch_valid_q;
   assign pitch_update = pitch_update_q;
   assign pitch_lost   = pitch_lost_q;

endmodule
